// File: rtl/gpio_axil_arb_pkg.sv
// gpio_axil_arb_pkg: shared types and constants for the two-requester GPIO AXI4-Lite arbiter.
package gpio_axil_arb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_R, S_RSP} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] REG0 = 4'h0;
  localparam logic [3:0] REG1 = 4'h4;
  localparam logic [3:0] REG2 = 4'h8;
  localparam logic [3:0] REG3 = 4'hC;
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; the pointer names the requester favoured on a tie.
module rr_arbiter2
  import gpio_axil_arb_pkg::*;
(
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_idx
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt_idx = (req == 2'b11) ? ptr_q : req[1];
    gnt     = (req == 2'b00) ? 2'b00 : onehot2(gnt_idx);
    ptr_d   = accept ? ~gnt_idx : ptr_q;
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
endmodule

// File: rtl/gpio_axil_arbiter.sv
// gpio_axil_arbiter: shares one AXI4-Lite register slave between two valid/ready requesters,
// one transaction at a time, with a one-cycle response pulse to the owner.
module gpio_axil_arbiter
  import gpio_axil_arb_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [1:0]                      req_write,
  input  logic [1:0][3:0]                 req_addr,
  input  logic [1:0][C_M_AXI_DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                      rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  state_t                          state_q, state_d;
  logic                            wr_q, wr_d;
  logic [1:0]                      addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                            gnt_q, gnt_d;
  logic                            aw_q, aw_d;
  logic                            w_q, w_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      resp_q, resp_d;
  logic [1:0]                      pick;
  logic                            pick_idx;
  logic                            accept;
  logic                            unused_addr_lsbs;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   axi_addr;

  rr_arbiter2 u_arb (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .req     (req_valid),
    .accept  (accept),
    .gnt     (pick),
    .gnt_idx (pick_idx)
  );

  // Ready is gated by reset so nothing is offered while the block is held in reset.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt_d     = gnt_q;
    aw_d      = aw_q;
    w_d       = w_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    req_ready = (state_q == S_IDLE && ARESETN) ? pick : 2'b00;
    accept    = |(req_valid & req_ready);
    case (state_q)
      S_IDLE: if (accept) begin
        wr_d    = req_write[pick_idx];
        addr_d  = req_addr[pick_idx][3:2];
        wdata_d = req_wdata[pick_idx];
        gnt_d   = pick_idx;
        aw_d    = wr_d;
        w_d     = wr_d;
        state_d = wr_d ? S_WR : S_RD_A;
      end
      S_WR: begin
        aw_d = aw_q & ~M_AXI_AWREADY;
        w_d  = w_q & ~M_AXI_WREADY;
        if (!aw_d && !w_d) state_d = S_WR_B;
      end
      S_WR_B: if (M_AXI_BVALID) begin
        resp_d  = M_AXI_BRESP;
        rdata_d = '0;
        state_d = S_RSP;
      end
      S_RD_A: if (M_AXI_ARREADY) state_d = S_RD_R;
      S_RD_R: if (M_AXI_RVALID) begin
        rdata_d = M_AXI_RDATA;
        resp_d  = M_AXI_RRESP;
        state_d = S_RSP;
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 2'b00;
      wdata_q <= '0;
      gnt_q   <= 1'b0;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      aw_q    <= aw_d;
      w_q     <= w_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  assign unused_addr_lsbs = ^{req_addr[0][1:0], req_addr[1][1:0]};
  assign axi_addr      = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({addr_q, 2'b00});
  assign M_AXI_AWADDR  = axi_addr;
  assign M_AXI_ARADDR  = axi_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_q;
  assign M_AXI_WVALID  = w_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_BREADY  = state_q == S_WR_B;
  assign M_AXI_ARVALID = state_q == S_RD_A;
  assign M_AXI_RREADY  = state_q == S_RD_R;
  assign rsp_valid     = (state_q == S_RSP) ? onehot2(gnt_q) : 2'b00;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign busy          = state_q != S_IDLE;
endmodule

// File: tb/tb_gpio_axil_arbiter.sv
// tb_gpio_axil_arbiter: directed scenarios plus random traffic against a transaction-level
// model of the arbiter and a delay-configurable AXI4-Lite register slave.
module tb_gpio_axil_arbiter;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid, rsp_resp;
  logic [1:0][3:0] req_addr = '0;
  logic [1:0][31:0] req_wdata = '0;
  logic [31:0] rsp_rdata;
  logic busy;
  logic [3:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
  logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [1:0] M_AXI_BRESP, M_AXI_RRESP;
  logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;

  gpio_axil_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave: each ready rises once its valid has waited the configured number of cycles.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0;
  bit rd_err = 0;
  int aw_wait, w_wait, ar_wait, b_wait, aw_cnt, w_cnt;
  logic aw_got, w_got;
  logic [3:0] aw_a;
  logic [31:0] w_dat;
  logic [31:0] smem [4];
  assign M_AXI_AWREADY = M_AXI_AWVALID && aw_wait >= aw_dly;
  assign M_AXI_WREADY  = M_AXI_WVALID && w_wait >= w_dly;
  assign M_AXI_ARREADY = M_AXI_ARVALID && ar_wait >= ar_dly;
  wire aw_now = M_AXI_AWVALID && M_AXI_AWREADY;
  wire w_now  = M_AXI_WVALID && M_AXI_WREADY;
  wire both   = (aw_got || aw_now) && (w_got || w_now);

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; aw_cnt <= 0; w_cnt <= 0;
      aw_got <= 0; w_got <= 0; aw_a <= 0; w_dat <= 0;
      M_AXI_BVALID <= 0; M_AXI_BRESP <= 0; M_AXI_RVALID <= 0; M_AXI_RRESP <= 0; M_AXI_RDATA <= 0;
      for (int i = 0; i < 4; i++) smem[i] <= 0;
    end else begin
      aw_wait <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_wait + 1 : 0;
      ar_wait <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_wait + 1 : 0;
      if (aw_now) begin aw_got <= 1; aw_a <= M_AXI_AWADDR; aw_cnt <= aw_cnt + 1; end
      if (w_now) begin w_got <= 1; w_dat <= M_AXI_WDATA; w_cnt <= w_cnt + 1; end
      if (M_AXI_BVALID && M_AXI_BREADY) begin M_AXI_BVALID <= 0; aw_cnt <= 0; w_cnt <= 0; end
      if (both && !M_AXI_BVALID) begin
        if (b_wait >= b_dly) begin
          M_AXI_BVALID <= 1; M_AXI_BRESP <= 2'b00; b_wait <= 0; aw_got <= 0; w_got <= 0;
          smem[aw_now ? M_AXI_AWADDR[3:2] : aw_a[3:2]] <= w_now ? M_AXI_WDATA : w_dat;
        end else b_wait <= b_wait + 1;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_RVALID <= 1;
        M_AXI_RDATA  <= smem[M_AXI_ARADDR[3:2]];
        M_AXI_RRESP  <= (rd_err && M_AXI_ARADDR[3:2] == 2'd2) ? 2'b10 : 2'b00;
      end else if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 0;
    end
  end

  // Reference model: commands in flight, a register array, and the last-granted requester.
  typedef struct { logic [1:0] g; logic wr; logic [1:0] idx; logic [31:0] d; int cyc; bit zw; bit err; } ent_t;
  ent_t q[$];
  int gq[$];
  logic [31:0] mmem [4] = '{default: 0};
  bit m_busy = 0, m_last = 1;
  int cyc = 0, acc_cnt = 0, rsp_cnt = 0;

  function automatic logic [1:0] rr(input logic [1:0] v, input bit last);
    return (v == 2'b11) ? (last ? 2'b01 : 2'b10) : v;
  endfunction

  always @(negedge ACLK) begin
    logic [1:0] er;
    ent_t e;
    bit w;
    cyc++;
    if (!ARESETN) begin
      q.delete(); m_busy = 0; m_last = 1;
      for (int i = 0; i < 4; i++) mmem[i] = 0;
    end else begin
      er = m_busy ? 2'b00 : rr(req_valid, m_last);
      chk("ready", req_ready, er);
      chk("busy", busy, m_busy);
      if (M_AXI_AWVALID) chk("aw_attr", {M_AXI_AWPROT, M_AXI_WSTRB}, {3'b000, 4'hF});
      if (M_AXI_ARVALID) chk("ar_prot", M_AXI_ARPROT, 0);
      if (M_AXI_BVALID && M_AXI_BREADY) chk("hs_per_write", {aw_cnt, w_cnt}, {32'd1, 32'd1});
      if (|rsp_valid) begin
        if (q.size() == 0) chk("spurious_rsp", rsp_valid, 0);
        else begin
          e = q.pop_front();
          chk("rsp_owner", rsp_valid, e.g);
          chk("rsp_rdata", rsp_rdata, e.wr ? 32'd0 : mmem[e.idx]);
          chk("rsp_resp", rsp_resp, e.err ? 2'b10 : 2'b00);
          if (e.zw) chk("latency", cyc - e.cyc, 3);
          if (e.wr) mmem[e.idx] = e.d;
          rsp_cnt++;
        end
        m_busy = 0;
      end
      if (|(req_valid & er)) begin
        w = er[1];
        e.g = er; e.wr = req_write[w]; e.idx = req_addr[w][3:2]; e.d = req_wdata[w]; e.cyc = cyc;
        e.zw = aw_dly == 0 && w_dly == 0 && b_dly == 0 && ar_dly == 0;
        e.err = rd_err && !e.wr && e.idx == 2'd2;
        q.push_back(e);
        m_busy = 1; m_last = w; gq.push_back(int'(w)); acc_cnt++;
      end
    end
  end

  task automatic set_req(input int r, input bit v, input bit wr, input logic [3:0] a, input logic [31:0] d);
    req_valid[r] = v; req_write[r] = wr; req_addr[r] = a; req_wdata[r] = d;
  endtask

  task automatic wait_cnt(input string tag, input bit rsp, input int target);
    int n;
    n = 0;
    while ((rsp ? rsp_cnt : acc_cnt) < target && n < 300) begin @(posedge ACLK); #1; n++; end
    if ((rsp ? rsp_cnt : acc_cnt) < target) chk(tag, rsp ? rsp_cnt : acc_cnt, target);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin @(posedge ACLK); #1; n++; end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic cmd(input int r, input bit wr, input logic [3:0] a, input logic [31:0] d);
    int ta, tr;
    ta = acc_cnt + 1; tr = rsp_cnt + 1;
    set_req(r, 1, wr, a, d);
    wait_cnt("acc_timeout", 0, ta);
    req_valid[r] = 0;
    wait_cnt("rsp_timeout", 1, tr);
  endtask

  initial begin
    int base, ta, tr, n;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_outs", {req_ready, rsp_valid, rsp_rdata, rsp_resp, busy, M_AXI_AWVALID, M_AXI_WVALID,
                     M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    ARESETN = 1;
    @(posedge ACLK); #1;
    // Write then read back all four registers from requester 0.
    for (int i = 0; i < 4; i++) cmd(0, 1, 4'(i * 4), 32'(i + 1));
    for (int i = 0; i < 4; i++) cmd(0, 0, 4'(i * 4), 0);
    // Contention: both hold valid; grants must alternate starting with requester 0.
    cmd(1, 0, 4'h4, 0);
    base = gq.size(); ta = acc_cnt + 4; tr = rsp_cnt + 4;
    set_req(0, 1, 1, 4'h4, 32'hA5A5_A5A5);
    set_req(1, 1, 1, 4'h4, 32'h5A5A_5A5A);
    wait_cnt("t2_acc", 0, ta);
    req_valid = 0;
    wait_cnt("t2_rsp", 1, tr);
    for (int k = 0; k < 4; k++) chk("t2_grant", gq[base + k], k % 2);
    cmd(0, 0, 4'h4, 0);
    // Skewed AW/W readiness in both orders.
    aw_dly = 3; w_dly = 0; cmd(0, 1, 4'h8, 32'h1111_2222);
    aw_dly = 0; w_dly = 3; cmd(1, 1, 4'h8, 32'h3333_4444);
    w_dly = 0; cmd(0, 0, 4'h8, 0);
    // Error response passthrough.
    rd_err = 1; cmd(1, 0, 4'h8, 0); rd_err = 0;
    // Reset while waiting for B.
    b_dly = 10;
    ta = acc_cnt + 1;
    set_req(0, 1, 1, 4'hC, 32'hDEAD_BEEF);
    wait_cnt("t5_acc", 0, ta);
    req_valid[0] = 0;
    n = 0;
    while (!M_AXI_BREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    chk("t5_in_wr_b", M_AXI_BREADY, 1);
    #2 ARESETN = 0;
    #1 chk("t5_rst_outs", {req_ready, rsp_valid, rsp_rdata, rsp_resp, busy, M_AXI_AWVALID, M_AXI_WVALID,
                           M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    b_dly = 0;
    @(posedge ACLK); #1;
    ARESETN = 1;
    base = gq.size(); ta = acc_cnt + 2; tr = rsp_cnt + 2;
    set_req(0, 1, 0, 4'hC, 0);
    set_req(1, 1, 0, 4'h0, 0);
    wait_cnt("t5_acc2", 0, ta);
    req_valid = 0;
    wait_cnt("t5_rsp", 1, tr);
    chk("t5_first", gq[base], 0);
    // Requester 1 pulses valid while requester 0 owns the bus.
    b_dly = 4;
    ta = acc_cnt + 1; tr = rsp_cnt + 1;
    set_req(0, 1, 1, 4'h0, 32'h6666_0000);
    wait_cnt("t6_acc", 0, ta);
    req_valid[0] = 0;
    @(posedge ACLK); #1;
    set_req(1, 1, 1, 4'h4, 32'h0BAD_0BAD);
    @(posedge ACLK); #1;
    req_valid[1] = 0;
    wait_cnt("t6_rsp", 1, tr);
    chk("t6_acc_count", acc_cnt, ta);
    b_dly = 0;
    // Random traffic in epochs of slave delays.
    for (int ep = 0; ep < 4; ep++) begin
      req_valid = 0;
      wait_idle();
      aw_dly = ep == 0 ? 0 : int'($urandom_range(0, 3));
      w_dly  = ep == 0 ? 0 : int'($urandom_range(0, 3));
      b_dly  = ep == 0 ? 0 : int'($urandom_range(0, 3));
      ar_dly = ep == 0 ? 0 : int'($urandom_range(0, 3));
      rd_err = ep == 3;
      repeat (100) begin
        @(posedge ACLK); #1;
        for (int r = 0; r < 2; r++)
          set_req(r, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      end
    end
    req_valid = 0;
    wait_idle();
    repeat (2) @(posedge ACLK);
    #1 chk("final_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
